// File: rtl/fitness_timer_pkg.sv
// Shared encodings and widths for the workout timer.
// State values are visible on the state output port.
package fitness_timer_pkg;

  localparam int unsigned MIN_W = 8;
  localparam int unsigned SEC_W = 6;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sec_prescaler.sv
// One-second tick generator: counts enabled cycles 0..TICKS_PER_SEC-1.
// tick is asserted on the wrap cycle.
module sec_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = enable && (cnt_q == LAST);

  // A disabled cycle holds the count, so a pause resumes mid-second.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/workout_timer.sv
// Workout countdown timer: IDLE/RUN/PAUSE/DONE FSM with minute/second counters.
// All outputs come straight from registers.
module workout_timer
  import fitness_timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MIN_W-1:0] duration,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [MIN_W-1:0] rem_min,
  output logic [SEC_W-1:0] rem_sec,
  output logic [1:0]       state,
  output logic             done
);

  state_e           state_q, state_d;
  logic [MIN_W-1:0] rem_min_q, rem_min_d;
  logic [SEC_W-1:0] rem_sec_q, rem_sec_d;
  logic             done_q, done_d;
  logic             pre_en;
  logic             pre_clr;
  logic             sec_tick;

  // A pause or stop cycle must not advance the prescaler, even on its wrap.
  assign pre_en = (state_q == RUN) && !pause && !stop;

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (pre_en),
    .clear  (pre_clr),
    .tick   (sec_tick)
  );

  always_comb begin
    state_d   = state_q;
    rem_min_d = rem_min_q;
    rem_sec_d = rem_sec_q;
    done_d    = 1'b0;
    pre_clr   = 1'b0;
    if (stop) begin
      state_d   = IDLE;
      rem_min_d = '0;
      rem_sec_d = '0;
      pre_clr   = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            pre_clr   = 1'b1;
            rem_sec_d = '0;
            if (duration != '0) begin
              state_d   = RUN;
              rem_min_d = duration;
            end else begin
              state_d   = DONE;
              rem_min_d = '0;
              done_d    = 1'b1;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (sec_tick) begin
            if (rem_sec_q != '0) begin
              rem_sec_d = rem_sec_q - 1'b1;
            end else if (rem_min_q != '0) begin
              rem_min_d = rem_min_q - 1'b1;
              rem_sec_d = SEC_MAX;
            end
            // 0:01 is the only value whose tick lands on 0:00.
            if ((rem_min_q == '0) && (rem_sec_q == SEC_W'(1))) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (start && !pause) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_min_q <= '0;
      rem_sec_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_min_q <= rem_min_d;
      rem_sec_q <= rem_sec_d;
      done_q    <= done_d;
    end
  end

  assign rem_min = rem_min_q;
  assign rem_sec = rem_sec_q;
  assign state   = state_q;
  assign done    = done_q;

endmodule

// File: tb/tb_workout_timer.sv
// Self-checking bench for workout_timer with TICKS_PER_SEC=4.
// Expected outputs come from an elapsed-cycle arithmetic model, queued per driven cycle.
module tb_workout_timer;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] duration = 8'd0;
  logic [7:0] rem_min;
  logic [5:0] rem_sec;
  logic [1:0] state;
  logic       done;

  workout_timer #(
    .TICKS_PER_SEC(T)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .duration (duration),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .rem_min  (rem_min),
    .rem_sec  (rem_sec),
    .state    (state),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] sb_q[$];
  logic [16:0] got;
  logic [16:0] exp_v;

  // Model: mode 0..3, total seconds loaded, counting cycles actually run.
  int   m_mode = 0;
  int   m_total = 0;
  int   m_active = 0;
  logic m_done = 1'b0;

  function automatic logic [16:0] model_vec();
    int rs;
    rs = (m_mode == 1 || m_mode == 2) ? (m_total - m_active / T) : 0;
    return {2'(m_mode), 8'(rs / 60), 6'(rs % 60), m_done};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_total = 0; m_active = 0; m_done = 1'b0;
  endtask

  task automatic cyc(input logic st, input logic pa, input logic sp, input logic [7:0] dur);
    start = st; pause = pa; stop = sp; duration = dur;
    m_done = 1'b0;
    if (sp) begin
      m_mode = 0; m_total = 0; m_active = 0;
    end else begin
      case (m_mode)
        0, 3: if (st) begin
          m_active = 0;
          if (dur != 8'd0) begin
            m_mode = 1; m_total = int'(dur) * 60;
          end else begin
            m_mode = 3; m_total = 0; m_done = 1'b1;
          end
        end
        1: if (pa) m_mode = 2;
           else begin
             m_active++;
             if (m_active == m_total * T) begin
               m_mode = 3; m_done = 1'b1;
             end
           end
        2: if (st && !pa) m_mode = 1;
        default: ;
      endcase
    end
    sb_q.push_back(model_vec());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({state, rem_min, rem_sec, done} !== 17'd0) begin
      n_errors++;
      $display("FAIL reset_init: got %h expected 0", {state, rem_min, rem_sec, done});
    end
    start = 1'b1; duration = 8'd2;
    @(posedge clk); #1;
    n_checks++;
    if ({state, rem_min, rem_sec, done} !== 17'd0) begin
      n_errors++;
      $display("FAIL reset_held: got %h expected 0", {state, rem_min, rem_sec, done});
    end
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      cyc(n == 0, 1'b0, n == 5, 8'd2);
      got = {state, rem_min, rem_sec, done}; exp_v = sb_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL reset_release[%0d]: st/min/sec/done got %0d/%0d/%0d/%0b expected %0d/%0d/%0d/%0b",
                 n, got[16:15], got[14:7], got[6:1], got[0], exp_v[16:15], exp_v[14:7], exp_v[6:1], exp_v[0]);
      end
    end
  endtask

  task automatic test_basic(input string name, input logic [7:0] dur, input int ncyc);
    int pulses = 0;
    for (int n = 0; n < ncyc; n++) begin
      cyc(n == 0, 1'b0, 1'b0, dur);
      got = {state, rem_min, rem_sec, done}; exp_v = sb_q.pop_front(); n_checks++;
      if (done) pulses++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL %s[%0d]: st/min/sec/done got %0d/%0d/%0d/%0b expected %0d/%0d/%0d/%0b",
                 name, n, got[16:15], got[14:7], got[6:1], got[0], exp_v[16:15], exp_v[14:7], exp_v[6:1], exp_v[0]);
      end
      if (n == 4 && dur == 8'd2) begin
        n_checks++;
        if ({rem_min, rem_sec} !== {8'd1, 6'd59}) begin
          n_errors++;
          $display("FAIL %s_first_tick: got %0d:%0d expected 1:59", name, rem_min, rem_sec);
        end
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++;
      $display("FAIL %s_done_pulses: got %0d expected 1", name, pulses);
    end
  endtask

  task automatic test_zero_duration();
    for (int n = 0; n < 5; n++) begin
      cyc(n == 0 || n == 2, 1'b0, n == 1, 8'd0);
      got = {state, rem_min, rem_sec, done}; exp_v = sb_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL zero_dur[%0d]: st/min/sec/done got %0d/%0d/%0d/%0b expected %0d/%0d/%0d/%0b",
                 n, got[16:15], got[14:7], got[6:1], got[0], exp_v[16:15], exp_v[14:7], exp_v[6:1], exp_v[0]);
      end
    end
  endtask

  task automatic test_pause();
    int pulses = 0;
    logic st, pa;
    for (int n = 0; n < 352; n++) begin
      st = (n == 0) || (n == 11) || (n == 12) || (n == 20) || (n == 120);
      pa = (n >= 8 && n <= 11) || (n >= 20 && n <= 119);
      cyc(st, pa, 1'b0, (n == 0) ? 8'd1 : 8'd9);
      got = {state, rem_min, rem_sec, done}; exp_v = sb_q.pop_front(); n_checks++;
      if (done) pulses++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL pause[%0d]: st/min/sec/done got %0d/%0d/%0d/%0b expected %0d/%0d/%0d/%0b",
                 n, got[16:15], got[14:7], got[6:1], got[0], exp_v[16:15], exp_v[14:7], exp_v[6:1], exp_v[0]);
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++;
      $display("FAIL pause_done_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_stop();
    int pulses = 0;
    for (int n = 0; n < 124; n++) begin
      cyc(n == 0, 1'b0, n == 121, (n < 5) ? 8'd3 : 8'd7);
      got = {state, rem_min, rem_sec, done}; exp_v = sb_q.pop_front(); n_checks++;
      if (done) pulses++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL stop[%0d]: st/min/sec/done got %0d/%0d/%0d/%0b expected %0d/%0d/%0d/%0b",
                 n, got[16:15], got[14:7], got[6:1], got[0], exp_v[16:15], exp_v[14:7], exp_v[6:1], exp_v[0]);
      end
      if (n == 120) begin
        n_checks++;
        if ({rem_min, rem_sec} !== {8'd2, 6'd30}) begin
          n_errors++;
          $display("FAIL stop_at_230: got %0d:%0d expected 2:30", rem_min, rem_sec);
        end
      end
    end
    n_checks++;
    if (pulses != 0) begin
      n_errors++;
      $display("FAIL stop_done_pulses: got %0d expected 0", pulses);
    end
  endtask

  task automatic test_async_reset();
    for (int n = 0; n < 10; n++) begin
      cyc(n == 0, 1'b0, 1'b0, 8'd2);
      got = {state, rem_min, rem_sec, done}; exp_v = sb_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL async_pre[%0d]: st/min/sec/done got %0d/%0d/%0d/%0b expected %0d/%0d/%0d/%0b",
                 n, got[16:15], got[14:7], got[6:1], got[0], exp_v[16:15], exp_v[14:7], exp_v[6:1], exp_v[0]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({state, rem_min, rem_sec, done} !== 17'd0) begin
      n_errors++;
      $display("FAIL async_reset: got %h expected 0", {state, rem_min, rem_sec, done});
    end
    #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic("basic", 8'd2, 483);
    test_basic("restart_done", 8'd1, 243);
    test_zero_duration();
    test_pause();
    test_stop();
    test_async_reset();
    test_basic("after_reset", 8'd2, 483);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/workout_timer.md
WORKOUT_TIMER -- requirements
Module: workout_timer

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 50_000_000, the number of clk cycles per timer second (minimum 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port duration, input, 8, the workout length in minutes from the time-calculation logic (T3 value).
REQ-005 The block SHALL have port start, input, 1, a level sampled each cycle: start from IDLE, resume from PAUSE, or restart from DONE.
REQ-006 The block SHALL have port pause, input, 1, a level sampled each cycle that freezes the countdown.
REQ-007 The block SHALL have port stop, input, 1, a level sampled each cycle that aborts to IDLE.
REQ-008 The block SHALL have port rem_min, output, 8, the remaining whole minutes.
REQ-009 The block SHALL have port rem_sec, output, 6, the remaining seconds, 0..59.
REQ-010 The block SHALL have port state, output, 2, the current state: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse on entry to DONE.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, PAUSE and DONE, all registered, with all outputs driven from registers.
REQ-013 Priority SHALL be: stop over everything, in every state, with IDLE, rem_min=0, rem_sec=0 and prescaler=0 on the next cycle.
REQ-014 IDLE or DONE with start=1 and duration!=0 SHALL load rem_min=duration, rem_sec=0 and prescaler=0, then enter RUN next cycle.
REQ-015 IDLE or DONE with start=1 and duration=0 SHALL go directly to DONE, with done pulsing on the next cycle.
REQ-016 duration SHALL be sampled only on a start-load cycle; changes at any other time are ignored.
REQ-017 In RUN, the prescaler SHALL count 0..TICKS_PER_SEC-1 and wrap; the wrap cycle is a second tick.
REQ-018 On a second tick: if rem_sec>0, rem_sec decrements; else rem_min decrements and rem_sec becomes 59.
REQ-019 The tick that makes {rem_min,rem_sec}=0:00 SHALL move to DONE on the same edge and pulse done for exactly one cycle.
REQ-020 First tick latency from the start-load cycle SHALL be exactly TICKS_PER_SEC cycles, and total RUN time exactly duration*60*TICKS_PER_SEC cycles.
REQ-021 RUN with pause=1 SHALL enter PAUSE; the prescaler and counts are held, and no tick is applied that cycle even at wrap.
REQ-022 In RUN, start SHALL be ignored; pause=1 and start=1 together in RUN SHALL enter PAUSE.
REQ-023 PAUSE with start=1 and pause=0 SHALL return to RUN, with the prescaler resuming from its held value; otherwise the block stays in PAUSE.
REQ-024 DONE SHALL hold 0:00 until start or stop; done does not re-pulse while in DONE.
REQ-025 rem_min SHALL never underflow; a decrement is never applied at 0:00.

Reset
REQ-026 rst_n low SHALL immediately (asynchronously) force state=IDLE, rem_min=0, rem_sec=0, done=0 and prescaler=0, including mid-RUN or mid-PAUSE.
REQ-027 After rst_n deasserts, the block SHALL stay in IDLE until a start cycle; a start held high across reset release takes effect on the first clock edge.

Structure
REQ-028 Package fitness_timer_pkg SHALL hold the state encoding (IDLE/RUN/PAUSE/DONE), SEC_MAX=59, and the width constants MIN_W=8 and SEC_W=6.
REQ-029 Sub-module sec_prescaler SHALL implement the tick generator (inputs enable, clear; output tick), parameterised by TICKS_PER_SEC.
REQ-030 The FSM and minute/second counters SHALL reside in workout_timer.

Verification (TICKS_PER_SEC=4)
REQ-031 duration=2, one-cycle start: rem=2:00; 4 cycles later 1:59; after 480 cycles 0:00, state=DONE, done high exactly 1 cycle.
REQ-032 duration=0, start: state=DONE and done pulse on the next cycle; rem stays 0:00.
REQ-033 duration=1, pause at cycle 10 held 100 cycles, then start: done at cycle 340 (240+100); counts frozen during pause, including a pause asserted on a wrap cycle.
REQ-034 duration=3, stop at 2:30: next cycle IDLE, 0:00, no done pulse; duration changed mid-RUN has no effect.
REQ-035 rst_n pulled low between clock edges mid-RUN: outputs read 0/IDLE before the next edge; a restart after release behaves as REQ-031.
REQ-036 From DONE, start with duration=1: reload to 1:00, RUN, done again after 240 cycles.
